// File: rtl/dual_rail_transmitter.sv
// dual_rail_transmitter
// Transmit side of a 2-phase dual-rail channel. A parallel word is sent
// MSB-first. A '0' bit is one transition on bit0_out and a '1' bit is one
// transition on bit1_out. After each bit the block waits for one toggle of the
// receiver's ack level. That level is resynchronised here because it is
// asynchronous to clk. If no acknowledge arrives within TIMEOUT cycles, the
// block parks in ERROR until reset.
module dual_rail_transmitter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             bit0_out,
  output logic             bit1_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             tx_done,
  output logic             timeout_err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TO_W  = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND     = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;

  logic [SYNC_STAGES-1:0] r_ackSync;
  logic                   r_ackSeen;
  logic [WIDTH-1:0]       r_shreg;
  logic [CNT_W-1:0]       r_bitCnt;
  logic [TO_W-1:0]        r_toCnt;
  logic                   r_bit0;
  logic                   r_bit1;
  logic                   r_txDone;
  logic                   r_timeoutErr;

  logic                   w_ackLevel;
  logic                   w_ackEvent;
  logic                   w_load;
  logic                   w_sendBit;
  logic                   w_advance;
  logic                   w_finish;
  logic                   w_expire;

  // Resynchronise the asynchronous ack level through a plain flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ackSync <= '0;
    end else begin
      r_ackSync <= {r_ackSync[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign w_ackLevel = r_ackSync[SYNC_STAGES-1];
  assign w_ackEvent = (w_ackLevel != r_ackSeen);

  // Remember the last consumed ack level; toggles outside ERROR are always absorbed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ackSeen <= 1'b0;
    end else if (w_ackEvent && (r_state != S_ERROR)) begin
      r_ackSeen <= w_ackLevel;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and the one-cycle control strobes that steer the datapath
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_sendBit   = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    w_expire    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          w_load      = 1'b1;
          w_nextState = S_SEND;
        end
      end
      S_SEND: begin
        w_sendBit   = 1'b1;
        w_nextState = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (w_ackEvent) begin
          if (r_bitCnt == '0) begin
            w_finish    = 1'b1;
            w_nextState = S_IDLE;
          end else begin
            w_advance   = 1'b1;
            w_nextState = S_SEND;
          end
        end else if (r_toCnt == TO_LIMIT) begin
          w_expire    = 1'b1;
          w_nextState = S_ERROR;
        end
      end
      S_ERROR: begin
        w_nextState = S_ERROR;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Capture the word on accept and shift out one bit per SEND cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (w_load) begin
      r_shreg <= data_in;
    end else if (w_sendBit) begin
      r_shreg <= r_shreg << 1;
    end
  end

  // Count the bits still waiting for an acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitCnt <= '0;
    end else if (w_load) begin
      r_bitCnt <= LAST_IDX;
    end else if (w_advance) begin
      r_bitCnt <= r_bitCnt - CNT_W'(1);
    end
  end

  // Measure how long the receiver has been silent since the last rail edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_toCnt <= '0;
    end else if (w_sendBit) begin
      r_toCnt <= '0;
    end else if (r_state == S_WAIT_ACK) begin
      r_toCnt <= r_toCnt + TO_W'(1);
    end
  end

  // Drive the rails: exactly one of them flips for each transmitted bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit0 <= 1'b0;
      r_bit1 <= 1'b0;
    end else if (w_sendBit) begin
      if (r_shreg[WIDTH-1]) begin
        r_bit1 <= ~r_bit1;
      end else begin
        r_bit0 <= ~r_bit0;
      end
    end
  end

  // Completion pulse and the sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txDone     <= 1'b0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_txDone <= w_finish;
      if (w_expire) begin
        r_timeoutErr <= 1'b1;
      end
    end
  end

  assign ready_out   = (r_state == S_IDLE) && !rst;
  assign busy        = (r_state == S_SEND) || (r_state == S_WAIT_ACK);
  assign bit0_out    = r_bit0;
  assign bit1_out    = r_bit1;
  assign tx_done     = r_txDone;
  assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_dual_rail_transmitter.sv
// tb_dual_rail_transmitter
// Drives words into the transmitter and plays the asynchronous receiver.
// A cycle-level model predicts the following for every cycle: when each rail
// edge must occur, which rail it must be on, and when tx_done, busy, ready_out
// and timeout_err must be seen.
module tb_dual_rail_transmitter;

   localparam int WIDTH_P   = 8;
   localparam int SYNC_P    = 2;
   localparam int TIMEOUT_P = 16;
   localparam int RX_DELAY  = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [WIDTH_P-1:0] data_in = '0;
   logic               valid_in = 1'b0;
   logic               ready_out;
   logic               bit0_out;
   logic               bit1_out;
   logic               ack_in = 1'b0;
   logic               busy;
   logic               tx_done;
   logic               timeout_err;

   dual_rail_transmitter #(
      .WIDTH      (WIDTH_P),
      .SYNC_STAGES(SYNC_P),
      .TIMEOUT    (TIMEOUT_P)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .bit0_out   (bit0_out),
      .bit1_out   (bit1_out),
      .ack_in     (ack_in),
      .busy       (busy),
      .tx_done    (tx_done),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit b;
      bit isLast;
   } bitEnt_t;

   bitEnt_t     expBits[$];
   bit          modelBusy = 1'b0;
   bit          modelErr = 1'b0;
   bit          started = 1'b0;
   bit          lastRst = 1'b0;
   bit          acceptPending = 1'b0;
   bit          ackEnable = 1'b1;
   bit          curLast = 1'b0;
   int          expToggleCyc = -1;
   int          expDoneCyc = -1;
   int          expErrCyc = -1;
   int          ackDueCyc = -1;
   int          n0Toggles = 0;
   int          n1Toggles = 0;
   int          doneCount = 0;
   logic [15:0] railSeq = '0;
   logic        prevB0 = 1'b0;
   logic        prevB1 = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle compare process: updates the model, checks the DUT against it,
   // acts as the receiver and predicts acceptances for the next edge.
   initial begin : compareProc
      logic t0;
      logic t1;
      bitEnt_t ent;
      forever begin
         @(negedge clk);
         if (lastRst) begin
            modelBusy     = 1'b0;
            modelErr      = 1'b0;
            acceptPending = 1'b0;
            expBits.delete();
            expToggleCyc  = -1;
            expDoneCyc    = -1;
            expErrCyc     = -1;
            ackDueCyc     = -1;
            ack_in        = 1'b0;
            started       = 1'b1;
            checkOutput("resetBit0", bit0_out, 0);
            checkOutput("resetBit1", bit1_out, 0);
            checkOutput("resetBusy", busy, 0);
            checkOutput("resetTxDone", tx_done, 0);
            checkOutput("resetTimeoutErr", timeout_err, 0);
         end else if (started) begin
            if (acceptPending) begin
               modelBusy     = 1'b1;
               expToggleCyc  = cyc + 1;
               acceptPending = 1'b0;
            end
            if (cyc == expDoneCyc) modelBusy = 1'b0;
            if (cyc == expErrCyc) begin
               modelErr  = 1'b1;
               modelBusy = 1'b0;
            end
            t0 = (bit0_out !== prevB0);
            t1 = (bit1_out !== prevB1);
            checkOutput("bothRails", t0 & t1, 0);
            if (t0) n0Toggles++;
            if (t1) n1Toggles++;
            if (t0 | t1) railSeq = {railSeq[14:0], t1};
            if (cyc == expToggleCyc) begin
               expToggleCyc = -1;
               checkOutput("toggleMissing", t0 | t1, 1);
               if ((t0 | t1) && (expBits.size() > 0)) begin
                  ent = expBits.pop_front();
                  checkOutput("railChoice", t1, ent.b);
                  curLast = ent.isLast;
                  if (ackEnable) ackDueCyc = cyc + RX_DELAY;
                  else expErrCyc = cyc + TIMEOUT_P;
               end
            end else begin
               checkOutput("unexpectedToggle", t0 | t1, 0);
            end
            checkOutput("txDone", tx_done, (cyc == expDoneCyc));
            if (tx_done === 1'b1) doneCount++;
            checkOutput("busy", busy, modelBusy);
            checkOutput("timeoutErr", timeout_err, modelErr);
         end
         prevB0 = bit0_out;
         prevB1 = bit1_out;
         if (started) checkOutput("ready", ready_out, (!modelBusy && !modelErr && !rst));
         if (started && !rst && (cyc == ackDueCyc)) begin
            ack_in    = ~ack_in;
            ackDueCyc = -1;
            if (curLast) expDoneCyc = cyc + SYNC_P + 1;
            else expToggleCyc = cyc + SYNC_P + 2;
         end
         if (started && !rst && valid_in && !modelBusy && !modelErr && !acceptPending) begin
            for (int i = WIDTH_P - 1; i >= 0; i--) begin
               expBits.push_back('{b: data_in[i], isLast: (i == 0)});
            end
            acceptPending = 1'b1;
         end
         lastRst = rst;
      end
   end

   // Present one word and wait until it is taken; optionally keep valid high afterwards
   task automatic applyStimulus(input logic [WIDTH_P-1:0] word, input bit hold);
      int k = 0;
      @(posedge clk);
      #1;
      data_in  = word;
      valid_in = 1'b1;
      @(negedge clk);
      while (!ready_out && k < 500) begin
         @(negedge clk);
         k++;
      end
      checkOutput("acceptWait", (k < 500), 1);
      @(posedge clk);
      #1;
      if (!hold) valid_in = 1'b0;
   endtask

   // Wait until the model says the channel has gone quiet
   task automatic waitIdle();
      int k = 0;
      while ((modelBusy || acceptPending || expToggleCyc >= 0 || ackDueCyc >= 0 || expDoneCyc > cyc) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      checkOutput("idleWait", (k < 1000), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic doReset(input int n);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic clearCounters();
      n0Toggles = 0;
      n1Toggles = 0;
      doneCount = 0;
      railSeq   = '0;
   endtask

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete, required finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : scenario
      int k;
      // Reset held three cycles with ack low
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t1Ready", ready_out, 1);
      checkOutput("t1Bit0", bit0_out, 0);
      checkOutput("t1Bit1", bit1_out, 0);
      checkOutput("t1Busy", busy, 0);
      checkOutput("t1TxDone", tx_done, 0);
      checkOutput("t1Err", timeout_err, 0);

      // Single word 8'hA5 with a well-behaved receiver
      clearCounters();
      applyStimulus(8'hA5, 1'b0);
      waitIdle();
      checkOutput("t2Bit1Count", n1Toggles, 4);
      checkOutput("t2Bit0Count", n0Toggles, 4);
      checkOutput("t2Order", railSeq[7:0], 8'hA5);
      checkOutput("t2Bit0End", bit0_out, 0);
      checkOutput("t2Bit1End", bit1_out, 0);
      checkOutput("t2DoneCount", doneCount, 1);

      // Back-to-back 8'hFF then 8'h00 with valid held high
      clearCounters();
      applyStimulus(8'hFF, 1'b1);
      data_in = 8'h00;
      applyStimulus(8'h00, 1'b0);
      waitIdle();
      checkOutput("t3Bit1Count", n1Toggles, 8);
      checkOutput("t3Bit0Count", n0Toggles, 8);
      checkOutput("t3Order", railSeq, 16'hFF00);
      checkOutput("t3DoneCount", doneCount, 2);
      checkOutput("t3Bit0End", bit0_out, 0);
      checkOutput("t3Bit1End", bit1_out, 0);

      // Silent receiver: one rail edge, then the timeout
      clearCounters();
      ackEnable = 1'b0;
      applyStimulus(8'h40, 1'b0);
      repeat (30) @(negedge clk);
      checkOutput("t4Err", timeout_err, 1);
      checkOutput("t4Ready", ready_out, 0);
      checkOutput("t4Busy", busy, 0);
      checkOutput("t4Bit0", bit0_out, 1);
      checkOutput("t4Bit1", bit1_out, 0);
      checkOutput("t4DoneCount", doneCount, 0);
      @(posedge clk);
      #1;
      data_in  = 8'hFF;
      valid_in = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("t4ReadyHeld", ready_out, 0);
      checkOutput("t4ToggleCount", n0Toggles + n1Toggles, 1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      ackEnable = 1'b1;
      doReset(2);
      checkOutput("t4ErrCleared", timeout_err, 0);
      checkOutput("t4ReadyAfter", ready_out, 1);
      checkOutput("t4Bit0After", bit0_out, 0);

      // Reset after the third bit of 8'h3C, then a fresh word
      clearCounters();
      applyStimulus(8'h3C, 1'b0);
      k = 0;
      while ((n0Toggles + n1Toggles) < 3 && k < 200) begin
         @(negedge clk);
         k++;
      end
      checkOutput("t5ThirdBitWait", (k < 200), 1);
      checkOutput("t5Bit1Before", bit1_out, 1);
      doReset(1);
      checkOutput("t5Ready", ready_out, 1);
      checkOutput("t5Bit0", bit0_out, 0);
      checkOutput("t5Bit1", bit1_out, 0);
      checkOutput("t5Busy", busy, 0);
      checkOutput("t5TxDone", tx_done, 0);
      checkOutput("t5DoneCount", doneCount, 0);
      repeat (4) @(negedge clk);
      clearCounters();
      applyStimulus(8'h96, 1'b0);
      waitIdle();
      checkOutput("t5FreshOrder", railSeq[7:0], 8'h96);
      checkOutput("t5FreshDone", doneCount, 1);
      checkOutput("t5FreshBit1", n1Toggles, 4);
      checkOutput("t5FreshBit0", n0Toggles, 4);

      // Spurious ack toggle while idle, then 8'h01
      clearCounters();
      @(posedge clk);
      #1;
      ack_in = ~ack_in;
      repeat (6) @(negedge clk);
      checkOutput("t6IdleBusy", busy, 0);
      checkOutput("t6IdleToggles", n0Toggles + n1Toggles, 0);
      checkOutput("t6IdleDone", doneCount, 0);
      applyStimulus(8'h01, 1'b0);
      waitIdle();
      checkOutput("t6Bit0Count", n0Toggles, 7);
      checkOutput("t6Bit1Count", n1Toggles, 1);
      checkOutput("t6Order", railSeq[7:0], 8'h01);
      checkOutput("t6DoneCount", doneCount, 1);
      checkOutput("t6Bit0End", bit0_out, 1);
      checkOutput("t6Bit1End", bit1_out, 1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
